// File: rtl/ws2812_bit_decoder.sv
// ws2812_bit_decoder: measures pulse widths on a WS2812-style serial line, classifies
// bits, assembles MSB-first pixels and flags frame ends and timing violations.
`default_nettype none
`timescale 1ns/1ps

module ws2812_bit_decoder #(
  parameter int CLK_PERIOD_NS  = 10,
  parameter int T0H_NS         = 350,
  parameter int T1H_NS         = 700,
  parameter int T0L_NS         = 800,
  parameter int T1L_NS         = 600,
  parameter int TOL_NS         = 150,
  parameter int TRESET_NS      = 50000,
  parameter int BITS_PER_PIXEL = 24,
  parameter int MAX_PIXELS     = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_din,
  output logic [BITS_PER_PIXEL-1:0]     o_pixel,
  output logic                          o_pixel_valid,
  output logic [$clog2(MAX_PIXELS)-1:0] o_pixel_index,
  output logic                          o_frame_end,
  output logic                          o_err_high,
  output logic                          o_err_low,
  output logic [15:0]                   o_err_count
);

  localparam int IW         = $clog2(MAX_PIXELS);
  localparam int BW         = $clog2(BITS_PER_PIXEL + 1);
  localparam int T0H_MIN    = (T0H_NS - TOL_NS) / CLK_PERIOD_NS;
  localparam int T0H_MAX    = (T0H_NS + TOL_NS) / CLK_PERIOD_NS;
  localparam int T1H_MIN    = (T1H_NS - TOL_NS) / CLK_PERIOD_NS;
  localparam int T1H_MAX    = (T1H_NS + TOL_NS) / CLK_PERIOD_NS;
  localparam int TL_LO_NS   = (T0L_NS < T1L_NS) ? T0L_NS : T1L_NS;
  localparam int TL_HI_NS   = (T0L_NS > T1L_NS) ? T0L_NS : T1L_NS;
  localparam int TL_MIN     = (TL_LO_NS - TOL_NS) / CLK_PERIOD_NS;
  localparam int TL_MAX     = (TL_HI_NS + TOL_NS) / CLK_PERIOD_NS;
  localparam int TRESET_CYC = TRESET_NS / CLK_PERIOD_NS;
  localparam int CW         = $clog2(TRESET_CYC + 1);

  localparam logic [CW-1:0] C_T0H_MIN = CW'(T0H_MIN);
  localparam logic [CW-1:0] C_T0H_MAX = CW'(T0H_MAX);
  localparam logic [CW-1:0] C_T1H_MIN = CW'(T1H_MIN);
  localparam logic [CW-1:0] C_T1H_MAX = CW'(T1H_MAX);
  localparam logic [CW-1:0] C_TL_MIN  = CW'(TL_MIN);
  localparam logic [CW-1:0] C_TL_MAX  = CW'(TL_MAX);
  localparam logic [CW-1:0] C_TRESET  = CW'(TRESET_CYC);
  localparam logic [BW-1:0] C_BPP     = BW'(BITS_PER_PIXEL);
  localparam logic [IW-1:0] C_IDX_MAX = IW'(MAX_PIXELS - 1);

  if (!(T0H_MAX < T1H_MIN || T1H_MAX < T0H_MIN)) begin : g_bad_high_windows
    $error("ws2812_bit_decoder: T0H and T1H windows overlap");
  end
  if (TL_MAX >= TRESET_CYC) begin : g_bad_low_window
    $error("ws2812_bit_decoder: low window reaches the reset time");
  end

  typedef enum logic [1:0] {
    WAIT_RESET = 2'd0,
    IDLE       = 2'd1,
    HIGH       = 2'd2,
    LOW        = 2'd3
  } state_t;

  state_t state, state_n;

  logic                      din_meta, din_sync, din_prev;
  logic                      rise, fall;
  logic [CW-1:0]             width_cnt;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [BW-1:0]             bit_cnt;
  logic [IW-1:0]             pix_idx;
  logic                      shift_en, shift_bit, drop;
  logic                      err_high_n, err_low_n, frame_end_n;
  logic                      in_t0h, in_t1h, in_low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_meta <= 1'b0;
      din_sync <= 1'b0;
      din_prev <= 1'b0;
    end else begin
      din_meta <= i_din;
      din_sync <= din_meta;
      din_prev <= din_sync;
    end
  end

  assign rise = din_sync & ~din_prev;
  assign fall = ~din_sync & din_prev;

  // Loaded with 1 on an edge so the value seen at the next edge equals the pulse width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_cnt <= '0;
    end else if (rise || fall) begin
      width_cnt <= CW'(1);
    end else if (width_cnt != C_TRESET) begin
      width_cnt <= width_cnt + 1'b1;
    end
  end

  assign in_t0h = (width_cnt >= C_T0H_MIN) && (width_cnt <= C_T0H_MAX);
  assign in_t1h = (width_cnt >= C_T1H_MIN) && (width_cnt <= C_T1H_MAX);
  assign in_low = (width_cnt >= C_TL_MIN) && (width_cnt <= C_TL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_RESET;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_en    = 1'b0;
    shift_bit   = 1'b0;
    drop        = 1'b0;
    err_high_n  = 1'b0;
    err_low_n   = 1'b0;
    frame_end_n = 1'b0;
    case (state)
      WAIT_RESET: begin
        if (!din_sync && !rise && width_cnt == C_TRESET) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          if (in_t0h || in_t1h) begin
            shift_en  = 1'b1;
            shift_bit = in_t1h;
            state_n   = LOW;
          end else begin
            err_high_n = 1'b1;
            drop       = 1'b1;
            state_n    = WAIT_RESET;
          end
        end else if (width_cnt == C_TRESET) begin
          err_high_n = 1'b1;
          drop       = 1'b1;
          state_n    = WAIT_RESET;
        end
      end
      LOW: begin
        if (rise) begin
          if (in_low) begin
            state_n = HIGH;
          end else begin
            err_low_n = 1'b1;
            drop      = 1'b1;
            state_n   = WAIT_RESET;
          end
        end else if (width_cnt == C_TRESET) begin
          frame_end_n = 1'b1;
          drop        = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = WAIT_RESET;
    endcase
  end

  // A dropped frame (error or latch) restarts pixel numbering at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      pix_idx       <= '0;
      o_pixel       <= '0;
      o_pixel_index <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      o_pixel_valid <= 1'b0;
      if (drop) begin
        shreg   <= '0;
        bit_cnt <= '0;
        pix_idx <= '0;
      end else if (bit_cnt == C_BPP) begin
        o_pixel       <= shreg;
        o_pixel_index <= pix_idx;
        o_pixel_valid <= 1'b1;
        bit_cnt       <= '0;
        if (pix_idx != C_IDX_MAX) begin
          pix_idx <= pix_idx + 1'b1;
        end
      end else if (shift_en) begin
        shreg   <= {shreg[BITS_PER_PIXEL-2:0], shift_bit};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_frame_end <= 1'b0;
      o_err_high  <= 1'b0;
      o_err_low   <= 1'b0;
      o_err_count <= '0;
    end else begin
      o_frame_end <= frame_end_n;
      o_err_high  <= err_high_n;
      o_err_low   <= err_low_n;
      if ((err_high_n || err_low_n) && o_err_count != 16'hFFFF) begin
        o_err_count <= o_err_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
